// File: rtl/ifetch_if.sv
// Instruction-memory request/response bus between the fetch unit and the memory.
// One request may be outstanding; each grant is answered by exactly one rvalid pulse.
interface ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: single-outstanding memory fetch with a one-entry skid
// buffer behind the IF/ID stall, and jump redirect that flushes in-flight data.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  ifetch_if.master    imem,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        inst_valid_q, inst_valid_d;

  logic req_s;
  logic gnt_s;
  logic rsp_s;
  logic accept_s;

  // Request is gated by rst so it drops the instant reset asserts.
  assign req_s           = rst && (state_q == S_REQ) && !buf_valid_q;
  assign gnt_s           = req_s && imem.imem_gnt;
  assign rsp_s           = imem.imem_rvalid;
  assign accept_s        = (state_q == S_WAIT) && rsp_s && !jump_en;
  assign imem.imem_req   = req_s;
  assign imem.imem_addr  = {fetch_pc_q[31:2], 2'b00};
  assign inst_out        = inst_out_q;
  assign pc_out          = pc_out_q;
  assign inst_valid      = inst_valid_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    buf_valid_d  = buf_valid_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    inst_out_d   = inst_out_q;
    pc_out_d     = pc_out_q;
    inst_valid_d = inst_valid_q;

    case (state_q)
      S_REQ: begin
        if (gnt_s) begin
          state_d    = S_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
          resp_pc_d  = fetch_pc_q;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (rsp_s) state_d = S_REQ;
        else       state_d = S_WAIT;
      end
      S_DROP: begin
        if (rsp_s) state_d = S_REQ;
        else       state_d = S_DROP;
      end
      default: state_d = S_REQ;
    endcase

    // A redirect with a response still owed parks in DROP to swallow it.
    if (jump_en) begin
      fetch_pc_d   = {jump_addr[31:2], 2'b00};
      buf_valid_d  = 1'b0;
      inst_out_d   = NOP_INST;
      inst_valid_d = 1'b0;
      if ((state_q == S_REQ) && gnt_s) begin
        state_d = S_DROP;
      end else if (((state_q == S_WAIT) || (state_q == S_DROP)) && !rsp_s) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else if (hold) begin
      if (accept_s) begin
        buf_valid_d = 1'b1;
        buf_inst_d  = imem.imem_rdata;
        buf_pc_d    = resp_pc_q;
      end else begin
        buf_valid_d = buf_valid_q;
      end
    end else if (buf_valid_q) begin
      inst_out_d   = buf_inst_q;
      pc_out_d     = buf_pc_q;
      inst_valid_d = 1'b1;
      buf_valid_d  = 1'b0;
    end else if (accept_s) begin
      inst_out_d   = imem.imem_rdata;
      pc_out_d     = resp_pc_q;
      inst_valid_d = 1'b1;
    end else begin
      inst_out_d   = NOP_INST;
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= 32'h0000_0000;
      buf_valid_q  <= 1'b0;
      buf_inst_q   <= 32'h0000_0000;
      buf_pc_q     <= 32'h0000_0000;
      inst_out_q   <= NOP_INST;
      pc_out_q     <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      buf_valid_q  <= buf_valid_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
      inst_out_q   <= inst_out_d;
      pc_out_q     <= pc_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a memory model answers grants after a settable latency,
// and two scoreboards check granted addresses and delivered instructions.
module tb_ifetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        gnt_en;
  int          mem_lat;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_out[$];
  logic [31:0] inst_out, pc_out;
  logic        inst_valid;

  ifetch_if bus();
  assign bus.imem_gnt = gnt_en;

  ifetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .hold(hold), .jump_en(jump_en), .jump_addr(jump_addr),
    .imem(bus), .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_rvalid(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1);
      if (bus.imem_rvalid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s rvalid timeout got 0 want 1", name);
    end
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] inst);
    exp_out.push_back({pc, inst});
  endtask

  // Memory model: checks each grant against the expected address, replies after mem_lat cycles.
  initial begin : mem_model
    logic        g;
    logic [31:0] a;
    logic        pend;
    logic [31:0] pa;
    int          cnt;
    pend = 1'b0;
    cnt = 0;
    pa = 32'h0000_0000;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0000_0000;
    forever begin
      @(posedge clk);
      g = rst && bus.imem_req && bus.imem_gnt;
      a = bus.imem_addr;
      #1;
      bus.imem_rvalid = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (g) begin
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_addr unexpected got %h want none", a);
          end else begin
            chk("grant_addr", a, exp_addr.pop_front());
          end
          pend = 1'b1;
          pa   = a;
          cnt  = mem_lat;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_data(pa);
            pend = 1'b0;
          end
        end
      end
    end
  end

  // Output monitor: every fresh valid output must match the head of the expected queue.
  initial begin : out_monitor
    logic        ph;
    logic [63:0] e;
    forever begin
      @(posedge clk);
      ph = hold;
      @(negedge clk);
      if (rst && !ph && inst_valid) begin
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected got pc %h want none", pc_out);
        end else begin
          e = exp_out.pop_front();
          chk("out_pc", pc_out, e[63:32]);
          chk("out_inst", inst_out, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; hold = 1'b0; jump_en = 1'b0; jump_addr = 32'h0000_0000;
    gnt_en = 1'b1; mem_lat = 1;
    #1 rst = 1'b0;
    step(2);
    chk("rst_inst", inst_out, NOP);
    chk("rst_pc", pc_out, 32'h0000_0000);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);

    // Streaming fetch with always-grant, one-cycle memory.
    exp_addr.push_back(32'h0000_0000);
    exp_addr.push_back(32'h0000_0004);
    exp_addr.push_back(32'h0000_0008);
    push_out(32'h0000_0000, 32'hC0DE_0000);
    push_out(32'h0000_0004, 32'hC0DE_0004);
    rst = 1'b1;
    #1;
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0000_0000);
    wait_rvalid("rsp0");
    wait_rvalid("rsp4");
    wait_rvalid("rsp8");

    // Stall while the 0x8 response lands in the skid buffer.
    hold = 1'b1;
    push_out(32'h0000_0008, 32'hC0DE_0008);
    step(1);
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_valid", {31'd0, inst_valid}, 32'd0);
    chk("hold_pc", pc_out, 32'h0000_0004);
    step(4);
    chk("hold5_pc", pc_out, 32'h0000_0004);
    chk("hold5_inst", inst_out, NOP);
    hold = 1'b0;
    exp_addr.push_back(32'h0000_000C);
    step(1);
    chk("unhold_pc", pc_out, 32'h0000_0008);
    chk("unhold_req", {31'd0, bus.imem_req}, 32'd1);
    chk("unhold_addr", bus.imem_addr, 32'h0000_000C);

    // Redirect while waiting for 0x10.
    push_out(32'h0000_000C, 32'hC0DE_000C);
    exp_addr.push_back(32'h0000_0010);
    mem_lat = 3;
    wait_rvalid("rspC");
    step(2);
    chk("wait10_req", {31'd0, bus.imem_req}, 32'd0);
    jump_en = 1'b1; jump_addr = 32'h0000_0100;
    step(1);
    jump_en = 1'b0;
    chk("jmp_valid", {31'd0, inst_valid}, 32'd0);
    chk("jmp_inst", inst_out, NOP);
    chk("drop_req", {31'd0, bus.imem_req}, 32'd0);
    exp_addr.push_back(32'h0000_0100);
    push_out(32'h0000_0100, 32'hC0DE_0100);
    wait_rvalid("rsp10_dropped");
    wait_rvalid("rsp100");
    step(1);

    // Redirect to a misaligned target under hold, no grant in that cycle.
    gnt_en = 1'b0; hold = 1'b1; jump_en = 1'b1; jump_addr = 32'h0000_0203;
    step(1);
    jump_en = 1'b0;
    chk("flush_valid", {31'd0, inst_valid}, 32'd0);
    chk("flush_inst", inst_out, NOP);
    chk("align_req", {31'd0, bus.imem_req}, 32'd1);
    chk("align_addr", bus.imem_addr, 32'h0000_0200);
    exp_addr.push_back(32'h0000_0200);
    push_out(32'h0000_0200, 32'hC0DE_0200);
    gnt_en = 1'b1; hold = 1'b0;
    wait_rvalid("rsp200");
    step(1);

    // Jump coinciding with a grant, then another jump coinciding with the dropped rvalid.
    exp_addr.push_back(32'h0000_0204);
    jump_en = 1'b1; jump_addr = 32'h0000_0400;
    step(1);
    jump_en = 1'b0;
    chk("gntjmp_req", {31'd0, bus.imem_req}, 32'd0);
    wait_rvalid("rsp204_dropped");
    jump_en = 1'b1; jump_addr = 32'h0000_0500;
    step(1);
    jump_en = 1'b0;
    chk("dropjmp_req", {31'd0, bus.imem_req}, 32'd1);
    chk("dropjmp_addr", bus.imem_addr, 32'h0000_0500);
    exp_addr.push_back(32'h0000_0500);
    push_out(32'h0000_0500, 32'hC0DE_0500);
    wait_rvalid("rsp500");
    step(1);

    // Address wrap at the top of memory, then reset in the middle of a wait.
    gnt_en = 1'b0; jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
    step(1);
    jump_en = 1'b0;
    chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    mem_lat = 1;
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0000_0000);
    push_out(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    gnt_en = 1'b1;
    wait_rvalid("rspFFFC");
    mem_lat = 3;
    step(1);
    chk("wrap_req", {31'd0, bus.imem_req}, 32'd1);
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
    step(1);
    chk("wrapwait_req", {31'd0, bus.imem_req}, 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_inst", inst_out, NOP);
    chk("arst_pc", pc_out, 32'h0000_0000);
    gnt_en = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    chk("rerst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rerst_addr", bus.imem_addr, 32'h0000_0000);
    step(3);
    chk("exp_out_left", exp_out.size(), 32'd0);
    chk("exp_addr_left", exp_addr.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h00000013, instruction presented when no valid fetch.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 hold  input  1  downstream stall; same signal that freezes the IF/ID register.
REQ-006 jump_en  input  1  redirect request from execute stage.
REQ-007 jump_addr  input  32  redirect target.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  32  request address, word aligned.
REQ-010 imem_gnt  input  1  request accepted in the cycle where imem_req=1 and imem_gnt=1.
REQ-011 imem_rvalid  input  1  response valid; in order; one cycle pulse per granted request; earliest one cycle after grant.
REQ-012 imem_rdata  input  32  response instruction.
REQ-013 inst_out  output  32  fetched instruction to IF/ID.
REQ-014 pc_out  output  32  address of inst_out.
REQ-015 inst_valid  output  1  inst_out/pc_out carry a real fetch.

Function
REQ-016 At most one request outstanding; FSM states REQ, WAIT, DROP.
REQ-017 REQ: imem_req=1 iff skid buffer empty; imem_addr=fetch_pc; on imem_gnt -> WAIT, fetch_pc+4 (mod 2^32, wraps FFFFFFFC->00000000), granted address latched as resp_pc.
REQ-018 WAIT: imem_req=0; on imem_rvalid -> REQ; no new request in the rvalid cycle, so peak throughput is one instruction per two cycles.
REQ-019 DROP: imem_req=0; response discarded on imem_rvalid; -> REQ.
REQ-020 Accepted response (WAIT+rvalid): if hold=0 and buffer empty, registered to inst_out=imem_rdata, pc_out=resp_pc, inst_valid=1 next edge; if hold=1, stored in 1-entry skid buffer.
REQ-021 hold=0 and buffer full: outputs load buffer contents, buffer clears, same edge.
REQ-022 hold=0, no response, buffer empty: inst_out=NOP_INST, pc_out unchanged, inst_valid=0.
REQ-023 hold=1 without jump_en: inst_out, pc_out and inst_valid unchanged.
REQ-024 Buffer full and rvalid in the same cycle cannot occur; no request issues while the buffer is full.
REQ-025 jump_en=1 has priority over hold and all other events: fetch_pc<=jump_addr with bits[1:0] forced to 0; buffer cleared; inst_out=NOP_INST, inst_valid=0 next edge.
REQ-026 jump_en in WAIT, or in REQ coinciding with imem_gnt -> DROP; a coincident rvalid in WAIT is discarded.
REQ-027 jump_en in REQ without gnt -> stay REQ; imem_addr shows the new target next cycle.
REQ-028 jump_en in DROP -> stay DROP, fetch_pc updated; a coincident rvalid is consumed as the dropped response and the FSM goes to REQ.
REQ-029 Output latency: rvalid cycle N -> inst_valid=1 after edge N+1 when hold=0.

Reset
REQ-030 rst=0 immediately forces: state REQ, fetch_pc=RESET_PC, buffer empty, inst_out=NOP_INST, pc_out=0, inst_valid=0, imem_req=0.
REQ-031 imem_req=1 with imem_addr=RESET_PC in the first cycle after rst rises.
REQ-032 Reset asserted mid-transaction abandons the outstanding request; the memory side is reset by the same rst.

Verification
REQ-033 Reset release, gnt always 1, rvalid one cycle after grant -> addresses 0,4,8 every second cycle; pc_out 0,4,8 with inst_valid=1 pulses.
REQ-034 hold=1 for 5 cycles while a response to 0x8 arrives -> outputs frozen, imem_req=0 after capture; hold=0 -> pc_out=0x8, then fetch 0xC resumes.
REQ-035 jump_en, jump_addr=0x100 while in WAIT for 0x10 -> 0x10 data never appears; next imem_addr=0x100; inst_valid=0 until 0x100 returns.
REQ-036 jump_en with jump_addr=0x203 and hold=1 -> outputs flushed to NOP_INST/valid 0; next fetch address 0x200.
REQ-037 jump_en simultaneous with rvalid in DROP -> one response discarded, next request to the latest jump target.
REQ-038 fetch_pc=0xFFFFFFFC granted -> next imem_addr=0x00000000; rst pulse mid-WAIT -> all outputs at reset values asynchronously.
